// File: rtl/multiplicador_secuencial_con_signo_pkg.sv
// Shared constants for the sequential signed Booth multiplier.
// Defaults and state encoding used by every file of the block.
package multiplicador_secuencial_con_signo_pkg;

  localparam int ANCHO_DEF = 16;
  localparam int FRAC_DEF  = 8;
  localparam int DOBLE_DEF = 2 * ANCHO_DEF;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    FIN     = 2'd2
  } estado_t;

endpackage

// File: rtl/multiplicador_secuencial_con_signo_if.sv
// Start/done handshake and result bus of the sequential multiplier.
// master drives operands and inicio; slave is the multiplier.
interface multiplicador_secuencial_con_signo_if
  import multiplicador_secuencial_con_signo_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) ();

  logic               inicio;
  logic [ANCHO-1:0]   operando1;
  logic [ANCHO-1:0]   operando2;
  logic               listo;
  logic               valido;
  logic [2*ANCHO-1:0] resultado_completo;
  logic [ANCHO-1:0]   resultado_truncado;
  logic               desborde;

  modport master (
    output inicio, operando1, operando2,
    input  listo, valido, resultado_completo,
    input  resultado_truncado, desborde
  );

  modport slave (
    input  inicio, operando1, operando2,
    output listo, valido, resultado_completo,
    output resultado_truncado, desborde
  );

endinterface

// File: rtl/multiplicador_secuencial_con_signo_redondeo_saturacion.sv
// Product to Q(ANCHO-FRAC).FRAC: round half up, arithmetic shift, clamp.
// Purely combinational; the parent registers its outputs.
module multiplicador_secuencial_con_signo_redondeo_saturacion #(
  parameter int ANCHO = 16,
  parameter int FRAC  = 8
) (
  input  logic [2*ANCHO-1:0] completo,
  output logic [ANCHO-1:0]   truncado,
  output logic               desborde
);

  localparam logic signed [2*ANCHO:0] MAXV =
    {{(ANCHO+2){1'b0}}, {(ANCHO-1){1'b1}}};
  localparam logic signed [2*ANCHO:0] MINV =
    {{(ANCHO+2){1'b1}}, {(ANCHO-1){1'b0}}};

  logic signed [2*ANCHO:0] ext;
  logic signed [2*ANCHO:0] sesgo;
  logic signed [2*ANCHO:0] red;
  logic signed [2*ANCHO:0] desp;
  logic                    alto;
  logic                    bajo;

  assign ext = {completo[2*ANCHO-1], completo};

  if (FRAC > 0) begin : g_sesgo
    assign sesgo = {{(2*ANCHO){1'b0}}, 1'b1} << (FRAC - 1);
  end else begin : g_sin_sesgo
    assign sesgo = '0;
  end

  // one extra bit keeps the rounding add from wrapping
  assign red  = ext + sesgo;
  assign desp = red >>> FRAC;
  assign alto = desp > MAXV;
  assign bajo = desp < MINV;

  assign desborde = alto | bajo;
  assign truncado = alto ? MAXV[ANCHO-1:0] :
                    bajo ? MINV[ANCHO-1:0] :
                           desp[ANCHO-1:0];

endmodule

// File: rtl/multiplicador_secuencial_con_signo.sv
// Radix-2 Booth signed multiplier, one step per cycle, start/done handshake.
// Registered full product plus rounded/saturated fixed-point result.
module multiplicador_secuencial_con_signo
  import multiplicador_secuencial_con_signo_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input logic clk,
  input logic reset,
  multiplicador_secuencial_con_signo_if.slave bus
);

  localparam int CW = $clog2(ANCHO);

  estado_t            estado;
  logic [CW-1:0]      cnt;
  logic [ANCHO:0]     a;
  logic [ANCHO:0]     m;
  logic [ANCHO:0]     suma;
  logic [ANCHO:0]     a_sig;
  logic [ANCHO-1:0]   q;
  logic [ANCHO-1:0]   q_sig;
  logic               qm1;
  logic [2*ANCHO-1:0] prod_sig;
  logic [ANCHO-1:0]   trunc_sig;
  logic               desb_sig;
  logic               listo;
  logic               valido;
  logic [2*ANCHO-1:0] completo;
  logic [ANCHO-1:0]   truncado;
  logic               desborde;

  always_comb begin
    suma = a;
    unique case ({q[0], qm1})
      2'b01:   suma = a + m;
      2'b10:   suma = a - m;
      default: suma = a;
    endcase
  end

  assign a_sig    = {suma[ANCHO], suma[ANCHO:1]};
  assign q_sig    = {suma[0], q[ANCHO-1:1]};
  assign prod_sig = {a_sig[ANCHO-1:0], q_sig};

  multiplicador_secuencial_con_signo_redondeo_saturacion #(
    .ANCHO (ANCHO),
    .FRAC  (FRAC)
  ) u_redondeo (
    .completo (prod_sig),
    .truncado (trunc_sig),
    .desborde (desb_sig)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= REPOSO;
      cnt      <= '0;
      a        <= '0;
      m        <= '0;
      q        <= '0;
      qm1      <= 1'b0;
      listo    <= 1'b1;
      valido   <= 1'b0;
      completo <= '0;
      truncado <= '0;
      desborde <= 1'b0;
    end else begin
      valido <= 1'b0;
      unique case (estado)
        REPOSO: begin
          if (bus.inicio) begin
            m      <= {bus.operando1[ANCHO-1], bus.operando1};
            a      <= '0;
            q      <= bus.operando2;
            qm1    <= 1'b0;
            cnt    <= CW'(ANCHO - 1);
            listo  <= 1'b0;
            estado <= CALCULO;
          end
        end
        CALCULO: begin
          a   <= a_sig;
          q   <= q_sig;
          qm1 <= q[0];
          cnt <= cnt - 1'b1;
          // results load from the final step's next-state values
          if (cnt == '0) begin
            completo <= prod_sig;
            truncado <= trunc_sig;
            desborde <= desb_sig;
            valido   <= 1'b1;
            estado   <= FIN;
          end
        end
        FIN: begin
          listo  <= 1'b1;
          estado <= REPOSO;
        end
        default: begin
          listo  <= 1'b1;
          estado <= REPOSO;
        end
      endcase
    end
  end

  assign bus.listo              = listo;
  assign bus.valido             = valido;
  assign bus.resultado_completo = completo;
  assign bus.resultado_truncado = truncado;
  assign bus.desborde           = desborde;

endmodule
